mtsp_mem_queue: RTL and testbench

//  Memory request queue directly downstream of the core's EX0 memory port.
//  - Consumes MEM_nEN/MEM_WRITE/MEM_ADDR/MEM_SRC/MEM_DATA_0 and buffers requests in a FIFO.
//  - Issues buffered requests in order on a req/grant bus to local memory.
//  - Returns read data to the core's EW1 extended-write port; back-pressures the core via MEM_STALL.

---
 rtl/mtsp_mem_queue_if.sv | 67 ++++++
 rtl/mtsp_mem_queue.sv | 242 ++++++++++++++++++++++++
 tb/tb_mtsp_mem_queue.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtsp_mem_queue_if.sv
// Memory-queue port bundle: core request side, local-memory bus side,
// extended-write return side and sticky error flags.
// Optional MTSP_MEMQ_PERF_EN adds the PERF_STALL_CNT stall counter output.
interface mtsp_mem_queue_if #(
    parameter int unsigned MEMID_W = 2,
    parameter int unsigned GPR_W   = 8,
    parameter int unsigned ADDR_W  = 16
);
    // core EX0 memory port
    logic [MEMID_W-1:0] MEM_nEN;
    logic               MEM_WRITE;
    logic [31:0]        MEM_ADDR;
    logic [GPR_W-1:0]   MEM_SRC;
    logic [127:0]       MEM_DATA_0;
    logic               MEM_STALL;

    // local memory req/grant bus
    logic               BUS_REQ;
    logic               BUS_WRITE;
    logic [ADDR_W-1:0]  BUS_ADDR;
    logic [127:0]       BUS_WDATA;
    logic               BUS_GRANT;
    logic               BUS_RVALID;
    logic [127:0]       BUS_RDATA;

    // core EW1 extended-write port
    logic               EW_nEN;
    logic [3:0]         EW_MASK;
    logic [GPR_W-1:0]   EW_ADDR;
    logic [127:0]       EW_DATA;

    // sticky error flags
    logic               ERR_OVF;
    logic               ERR_UNEXP;

`ifdef MTSP_MEMQ_PERF_EN
    logic [31:0]        PERF_STALL_CNT;
`else
    // no performance counter in this build
`endif

    // queue side
    modport slave (
        input  MEM_nEN, MEM_WRITE, MEM_ADDR, MEM_SRC, MEM_DATA_0,
        input  BUS_GRANT, BUS_RVALID, BUS_RDATA,
        output MEM_STALL,
        output BUS_REQ, BUS_WRITE, BUS_ADDR, BUS_WDATA,
        output EW_nEN, EW_MASK, EW_ADDR, EW_DATA,
        output ERR_OVF, ERR_UNEXP
`ifdef MTSP_MEMQ_PERF_EN
        , output PERF_STALL_CNT
`endif
    );

    // environment side (core + memory)
    modport master (
        output MEM_nEN, MEM_WRITE, MEM_ADDR, MEM_SRC, MEM_DATA_0,
        output BUS_GRANT, BUS_RVALID, BUS_RDATA,
        input  MEM_STALL,
        input  BUS_REQ, BUS_WRITE, BUS_ADDR, BUS_WDATA,
        input  EW_nEN, EW_MASK, EW_ADDR, EW_DATA,
        input  ERR_OVF, ERR_UNEXP
`ifdef MTSP_MEMQ_PERF_EN
        , input PERF_STALL_CNT
`endif
    );
endinterface

// File: rtl/mtsp_mem_queue.sv
// Memory request queue downstream of the core EX0 memory port.
// Buffers requests in a FIFO, issues them in order on a req/grant bus,
// tracks outstanding reads in a tag FIFO and returns read data on EW1.
// Optional MTSP_MEMQ_PERF_EN adds a saturating MEM_STALL cycle counter.
module mtsp_mem_queue #(
    parameter int unsigned MEM_ID   = 0,
    parameter int unsigned MEMID_W  = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RD_DEPTH = 4,
    parameter int unsigned SKID     = 2,
    parameter int unsigned GPR_W    = 8,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    mtsp_mem_queue_if.slave   mq
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned TPTR_W   = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int unsigned TCNT_W   = $clog2(RD_DEPTH) + 1;
    localparam int unsigned STALL_TH = DEPTH - SKID;
    localparam logic [MEMID_W-1:0] ID_MASK = MEMID_W'(1) << MEM_ID;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [GPR_W-1:0]  src;
        logic [127:0]      data;
    } req_t;

    // request FIFO
    req_t              fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    // outstanding-read tag FIFO
    logic [GPR_W-1:0]  tag_mem [RD_DEPTH];
    logic [TPTR_W-1:0] tag_wr_ptr;
    logic [TPTR_W-1:0] tag_rd_ptr;
    logic [TCNT_W-1:0] tag_count;
    logic [TCNT_W-1:0] tag_count_next;

    // registered outputs
    logic              mem_stall;
    logic              ew_n_en;
    logic [3:0]        ew_mask;
    logic [GPR_W-1:0]  ew_addr;
    logic [127:0]      ew_data;
    logic              err_ovf;
    logic              err_unexp;

    // per-cycle control strobes
    req_t              head;
    logic              empty;
    logic              full;
    logic              tag_empty;
    logic              tag_full;
    logic              rdblk;
    logic              bus_req_c;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              ovf_evt;
    logic              tag_push;
    logic              tag_pop;
    logic              unexp_evt;

    // upper address bits and foreign enable bits are not consumed here
    logic              unused_bits;
    assign unused_bits = ^{mq.MEM_ADDR[31:ADDR_W], mq.MEM_nEN};

    assign head = fifo_mem[rd_ptr];

    // decode push/pop/tag events for this cycle
    always_comb begin
        empty          = 1'b0;
        full           = 1'b0;
        tag_empty      = 1'b0;
        tag_full       = 1'b0;
        rdblk          = 1'b0;
        bus_req_c      = 1'b0;
        push_req       = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        ovf_evt        = 1'b0;
        tag_push       = 1'b0;
        tag_pop        = 1'b0;
        unexp_evt      = 1'b0;
        count_next     = count;
        tag_count_next = tag_count;

        empty     = (count == '0);
        full      = (count == CNT_W'(DEPTH));
        tag_empty = (tag_count == '0);
        tag_full  = (tag_count == TCNT_W'(RD_DEPTH));

        // a read at the head cannot issue while no tag slot is free
        rdblk     = !head.write && tag_full;
        bus_req_c = !empty && !rdblk;
        pop       = bus_req_c && mq.BUS_GRANT;

        // a push into a full FIFO is accepted when the head leaves this cycle
        push_req  = |(ID_MASK & ~mq.MEM_nEN);
        push      = push_req && (!full || pop);
        ovf_evt   = push_req && full && !pop;

        tag_push  = pop && !head.write;
        tag_pop   = mq.BUS_RVALID && !tag_empty;
        unexp_evt = mq.BUS_RVALID && tag_empty;

        count_next     = count + CNT_W'(push) - CNT_W'(pop);
        tag_count_next = tag_count + TCNT_W'(tag_push) - TCNT_W'(tag_pop);
    end

    // request FIFO storage; contents are qualified by count so no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: mq.MEM_WRITE,
                                   addr:  mq.MEM_ADDR[ADDR_W-1:0],
                                   src:   mq.MEM_SRC,
                                   data:  mq.MEM_DATA_0};
        end
    end

    // request FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // tag FIFO storage; holds destination GPR of each issued read
    always_ff @(posedge CLK) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr] <= head.src;
        end
    end

    // tag FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
        end else begin
            if (tag_push) begin
                tag_wr_ptr <= (tag_wr_ptr == TPTR_W'(RD_DEPTH - 1)) ? '0 : tag_wr_ptr + TPTR_W'(1);
            end
            if (tag_pop) begin
                tag_rd_ptr <= (tag_rd_ptr == TPTR_W'(RD_DEPTH - 1)) ? '0 : tag_rd_ptr + TPTR_W'(1);
            end
            tag_count <= tag_count_next;
        end
    end

    // stall once occupancy reaches the skid threshold; skid absorbs the latency
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mem_stall <= 1'b0;
        end else begin
            mem_stall <= (count_next >= CNT_W'(STALL_TH));
        end
    end

    // read return onto the extended-write port, one cycle after RVALID
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ew_n_en <= 1'b1;
            ew_mask <= '0;
            ew_addr <= '0;
            ew_data <= '0;
        end else begin
            ew_n_en <= !tag_pop;
            if (tag_pop) begin
                ew_mask <= 4'b1111;
                ew_addr <= tag_mem[tag_rd_ptr];
                ew_data <= mq.BUS_RDATA;
            end
        end
    end

    // sticky error flags
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_ovf   <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            if (ovf_evt) begin
                err_ovf <= 1'b1;
            end
            if (unexp_evt) begin
                err_unexp <= 1'b1;
            end
        end
    end

`ifdef MTSP_MEMQ_PERF_EN
    logic [31:0] perf_cnt;

    // saturating count of stalled cycles
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_cnt <= '0;
        end else if (mem_stall && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign mq.PERF_STALL_CNT = perf_cnt;
`else
    // stall counter not present in this build
`endif

    // bus side is driven straight from the FIFO head; zero while empty
    assign mq.BUS_REQ   = bus_req_c;
    assign mq.BUS_WRITE = !empty && head.write;
    assign mq.BUS_ADDR  = empty ? '0 : head.addr;
    assign mq.BUS_WDATA = empty ? '0 : head.data;

    assign mq.MEM_STALL = mem_stall;
    assign mq.EW_nEN    = ew_n_en;
    assign mq.EW_MASK   = ew_mask;
    assign mq.EW_ADDR   = ew_addr;
    assign mq.EW_DATA   = ew_data;
    assign mq.ERR_OVF   = err_ovf;
    assign mq.ERR_UNEXP = err_unexp;

endmodule

// File: tb/tb_mtsp_mem_queue.sv
// Scoreboard bench for mtsp_mem_queue: a queue-based reference model predicts
// bus issue order, read returns and per-cycle flags; a negedge monitor checks.
`timescale 1ns/1ps
module tb_mtsp_mem_queue;

    localparam int unsigned MEM_ID   = 0;
    localparam int unsigned MEMID_W  = 2;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned RD_DEPTH = 4;
    localparam int unsigned SKID     = 2;
    localparam int unsigned GPR_W    = 8;
    localparam int unsigned ADDR_W   = 16;
    localparam logic [MEMID_W-1:0] ID_MASK = MEMID_W'(1) << MEM_ID;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mtsp_mem_queue_if #(.MEMID_W(MEMID_W), .GPR_W(GPR_W), .ADDR_W(ADDR_W)) bus ();

    mtsp_mem_queue #(
        .MEM_ID(MEM_ID), .MEMID_W(MEMID_W), .DEPTH(DEPTH), .RD_DEPTH(RD_DEPTH),
        .SKID(SKID), .GPR_W(GPR_W), .ADDR_W(ADDR_W)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .mq(bus)
    );

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [GPR_W-1:0]  src;
        logic [127:0]      data;
    } req_t;

    typedef struct {
        logic [GPR_W-1:0] src;
        logic [127:0]     data;
    } ew_t;

    typedef struct {
        logic req;
        logic stall;
        logic ovf;
        logic unexp;
    } st_t;

    // reference model state
    req_t             m_q[$];
    logic [GPR_W-1:0] m_tags[$];
    bit               m_ovf;
    bit               m_unexp;
    int unsigned      stall_cycles;
    int unsigned      perf_exp;

    // scoreboard queues
    req_t exp_bus[$];
    ew_t  exp_ew[$];
    st_t  exp_st[$];

    int  tests = 0;
    int  fails = 0;
    bit  started = 0;

    logic [127:0] a5 = {4{32'hA5A5_A5A5}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT activity with nothing expected", name);
    endtask

    // one clock cycle: record expected state, drive inputs, advance model
    task automatic cycle(input bit rst, input bit push, input bit wr, input logic [31:0] addr,
                         input logic [GPR_W-1:0] src, input logic [127:0] data,
                         input bit grant, input bit rvalid, input logic [127:0] rdata);
        st_t s;
        bit req_m, pop_m, full_m, tpop;
        logic [MEMID_W-1:0] nen;
        @(posedge CLK);
        #2;
        started = 1;
        if (rst) begin
            nRST = 1'b0;
            m_q.delete();
            m_tags.delete();
            exp_bus.delete();
            exp_ew.delete();
            m_ovf = 0;
            m_unexp = 0;
            stall_cycles = 0;
            push = 0;
            grant = 0;
            rvalid = 0;
        end else begin
            nRST = 1'b1;
        end

        req_m = (m_q.size() > 0) && !(!m_q[0].wr && (m_tags.size() == RD_DEPTH));
        s.req   = req_m;
        s.stall = (m_q.size() >= DEPTH - SKID);
        s.ovf   = m_ovf;
        s.unexp = m_unexp;
        exp_st.push_back(s);
        perf_exp = stall_cycles;
        if (s.stall) stall_cycles++;

        nen = MEMID_W'($urandom);
        nen = push ? (nen & ~ID_MASK) : (nen | ID_MASK);
        bus.MEM_nEN    = nen;
        bus.MEM_WRITE  = wr;
        bus.MEM_ADDR   = addr;
        bus.MEM_SRC    = src;
        bus.MEM_DATA_0 = data;
        bus.BUS_GRANT  = grant;
        bus.BUS_RVALID = rvalid;
        bus.BUS_RDATA  = rdata;

        pop_m = req_m && grant;
        if (pop_m) exp_bus.push_back(m_q[0]);
        tpop = rvalid && (m_tags.size() > 0);
        if (tpop) exp_ew.push_back('{m_tags[0], rdata});
        if (rvalid && (m_tags.size() == 0)) m_unexp = 1;
        if (pop_m && !m_q[0].wr) m_tags.push_back(m_q[0].src);
        if (tpop) void'(m_tags.pop_front());
        full_m = (m_q.size() == DEPTH);
        if (push && full_m && !pop_m) m_ovf = 1;
        if (pop_m) void'(m_q.pop_front());
        if (push && (!full_m || pop_m)) m_q.push_back('{wr, addr[ADDR_W-1:0], src, data});
    endtask

    task automatic idle(input bit grant, input bit rvalid, input logic [127:0] rdata);
        cycle(0, 0, 0, 32'h0, '0, '0, grant, rvalid, rdata);
    endtask

    task automatic push_req(input bit wr, input logic [31:0] addr, input logic [GPR_W-1:0] src,
                            input bit grant);
        cycle(0, 1, wr, addr, src, {$urandom, $urandom, $urandom, $urandom}, grant, 0, '0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 32'h0, '0, '0, 0, 0, '0);
    endtask

    task automatic rand_cycle(input int push_pct, input int grant_pct, input int rv_pct);
        bit rv;
        rv = ($urandom_range(99) < rv_pct) && (m_tags.size() > 0);
        cycle(0, $urandom_range(99) < push_pct, $urandom_range(1), $urandom, GPR_W'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, $urandom_range(99) < grant_pct,
              rv, {$urandom, $urandom, $urandom, $urandom});
    endtask

    // monitor: compare DUT outputs against scoreboard once per cycle
    st_t  mon_s;
    req_t mon_r;
    ew_t  mon_e;
    always @(negedge CLK) begin
        if (started) begin
            if (exp_st.size() == 0) begin
                fail_now("state_underflow");
            end else begin
                mon_s = exp_st.pop_front();
                check("bus_req", bus.BUS_REQ, mon_s.req);
                check("mem_stall", bus.MEM_STALL, mon_s.stall);
                check("err_ovf", bus.ERR_OVF, mon_s.ovf);
                check("err_unexp", bus.ERR_UNEXP, mon_s.unexp);
            end
            if (bus.BUS_REQ && bus.BUS_GRANT) begin
                if (exp_bus.size() == 0) begin
                    fail_now("bus_issue");
                end else begin
                    mon_r = exp_bus.pop_front();
                    check("bus_write", bus.BUS_WRITE, mon_r.wr);
                    check("bus_addr", bus.BUS_ADDR, mon_r.addr);
                    check("bus_wdata", bus.BUS_WDATA, mon_r.data);
                end
            end
            if (!bus.EW_nEN) begin
                if (exp_ew.size() == 0) begin
                    fail_now("ew_return");
                end else begin
                    mon_e = exp_ew.pop_front();
                    check("ew_addr", bus.EW_ADDR, mon_e.src);
                    check("ew_mask", bus.EW_MASK, 4'hF);
                    check("ew_data", bus.EW_DATA, mon_e.data);
                end
            end
        end
    end

    initial begin
        int guard;
        bus.MEM_nEN    = '1;
        bus.MEM_WRITE  = 1'b0;
        bus.MEM_ADDR   = '0;
        bus.MEM_SRC    = '0;
        bus.MEM_DATA_0 = '0;
        bus.BUS_GRANT  = 1'b0;
        bus.BUS_RVALID = 1'b0;
        bus.BUS_RDATA  = '0;

        do_reset();
        do_reset();
        #1;
        check("rst_ew_nen", bus.EW_nEN, 1'b1);
        check("rst_ew_mask", bus.EW_MASK, 4'h0);
        check("rst_ew_addr", bus.EW_ADDR, '0);
        check("rst_ew_data", bus.EW_DATA, '0);
        check("rst_bus_addr", bus.BUS_ADDR, '0);
        check("rst_bus_wdata", bus.BUS_WDATA, '0);

        // single read: issue at t+1, return one cycle after RVALID
        cycle(0, 1, 0, 32'h0000_0010, GPR_W'(5), '0, 0, 0, '0);
        idle(1, 0, '0);
        idle(1, 0, '0);
        idle(1, 1, a5);
        idle(0, 0, '0);
        idle(0, 0, '0);

        // fill with no grant, stall, then overflow on the 5th push
        for (int i = 0; i < 5; i++) push_req($urandom_range(1), 32'h100 + i, GPR_W'(i), 0);
        idle(0, 0, '0);

        // full FIFO with simultaneous push and grant: no overflow, order kept
        do_reset();
        for (int i = 0; i < 4; i++) push_req(1, 32'h200 + i, GPR_W'(i), 0);
        push_req(1, 32'h2FF, GPR_W'(9), 1);
        push_req(0, 32'h2FE, GPR_W'(10), 1);
        for (int i = 0; i < 6; i++) idle(1, 0, '0);
        while (m_tags.size() > 0) idle(0, 1, {4{$urandom}});
        idle(0, 0, '0);

        // tag FIFO full blocks the 5th read until a tag returns
        do_reset();
        for (int i = 0; i < 5; i++) push_req(0, 32'h300 + i, GPR_W'(20 + i), 1);
        for (int i = 0; i < 3; i++) idle(1, 0, '0);
        idle(1, 1, {4{$urandom}});
        idle(1, 0, '0);
        idle(1, 0, '0);
        while (m_tags.size() > 0) idle(1, 1, {4{$urandom}});
        idle(0, 0, '0);

        // RVALID with nothing outstanding
        idle(0, 1, a5);
        idle(0, 0, '0);
        idle(0, 0, '0);

        // reset with queued requests and outstanding reads, then stray RVALID
        do_reset();
        push_req(0, 32'h400, GPR_W'(1), 1);
        push_req(0, 32'h401, GPR_W'(2), 1);
        push_req(1, 32'h402, GPR_W'(3), 0);
        push_req(0, 32'h403, GPR_W'(4), 0);
        push_req(1, 32'h404, GPR_W'(5), 0);
        do_reset();
        idle(0, 0, '0);
        idle(0, 1, a5);
        idle(0, 0, '0);

        // randomized traffic with mixed pressure profiles
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(399) == 0) do_reset();
                else case (p)
                    0: rand_cycle(50, 70, 50);
                    1: rand_cycle(90, 30, 30);
                    2: rand_cycle(30, 90, 80);
                    default: rand_cycle(70, 60, 10);
                endcase
            end
        end

        // drain everything that is still queued or outstanding
        guard = 0;
        while ((m_q.size() > 0 || m_tags.size() > 0) && guard < 300) begin
            idle(1, m_tags.size() > 0, {4{$urandom}});
            guard++;
        end
        if (guard >= 300) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: queue %0d tags %0d left, required 0", m_q.size(), m_tags.size());
        end
        idle(0, 0, '0);
        idle(0, 0, '0);
`ifdef MTSP_MEMQ_PERF_EN
        check("perf_stall_cnt", bus.PERF_STALL_CNT, perf_exp);
`endif
        @(negedge CLK);
        #1;
        check("bus_leftover", exp_bus.size(), 0);
        check("ew_leftover", exp_ew.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
